// File: rtl/pipe_check_pkg.sv
// pipe_check_pkg: shared opcodes, funct3 codes, delay-line entry and FSM states for the pipeline checker
package pipe_check_pkg;
   typedef enum logic [6:0] {
      ALU_OP   = 7'b0110011,
      ALU_OP_I = 7'b0010011,
      LOAD     = 7'b0000011,
      STORE    = 7'b0100011,
      BRANCH   = 7'b1100011
   } opcode_t;
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   typedef struct packed {
      logic        valid;
      logic        chk;
      logic [31:0] instr;
   } entry_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/pipe_check_model.sv
// pipe_check_model: combinational reference result for the checked ALU subset
module pipe_check_model
   import pipe_check_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic [XLEN-1:0] expected,
   output logic            chk
);
   logic [XLEN-1:0] opb;
   logic [2:0]      f3;
   logic            reg_op;
   logic            imm_op;
   logic            unused_fields;
   assign unused_fields = ^{instr[19:15], instr[11:7]};
   // Decode the supported ops; register form uses rs2, immediate form the sign-extended instr[31:20]
   always_comb begin
      f3       = instr[14:12];
      reg_op   = instr[6:0] == ALU_OP;
      imm_op   = instr[6:0] == ALU_OP_I;
      opb      = reg_op ? rs2 : {{(XLEN-12){instr[31]}}, instr[31:20]};
      expected = f3 == F3_ADD ? (reg_op && instr[30] ? rs1 - opb : rs1 + opb) :
                 f3 == F3_XOR ? rs1 ^ opb :
                 f3 == F3_OR  ? rs1 | opb : rs1 & opb;
      chk      = (reg_op || imm_op) && (f3 == F3_ADD || f3 == F3_XOR || f3 == F3_OR || f3 == F3_AND);
   end
endmodule

// File: rtl/pipe_check_monitor.sv
// pipe_check_monitor: ID-to-check delay line comparing a reference result with the core ALU result.
// Define PIPE_CHECK_TRACE_EN to print every check and the final tallies (simulation only).
module pipe_check_monitor
   import pipe_check_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 2,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 20
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             id_valid_i,
   input  logic [31:0]      id_instr_i,
   input  logic [XLEN-1:0]  id_rs1_val_i,
   input  logic [XLEN-1:0]  id_rs2_val_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [XLEN-1:0]  alu_result_i,
   output logic             chk_valid_o,
   output logic             chk_pass_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic [31:0]      first_fail_instr_o,
   output logic             first_fail_valid_o,
   output logic             done_o
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   state_t          state;
   logic [WD_W-1:0] wd;
   entry_t          line [DEPTH];
   logic [XLEN-1:0] exp_line [DEPTH];
   logic [XLEN-1:0] m_exp;
   logic            m_chk;
   logic            run;
   logic            check;
   logic            pass;
   pipe_check_model #(.XLEN(XLEN)) u_model (
      .instr   (id_instr_i),
      .rs1     (id_rs1_val_i),
      .rs2     (id_rs2_val_i),
      .expected(m_exp),
      .chk     (m_chk)
   );
   assign run   = state == RUN;
   assign check = run && line[DEPTH-1].valid && line[DEPTH-1].chk && !stall_i;
   assign pass  = exp_line[DEPTH-1] == alu_result_i;
   // Delay line: capture at entry 0, shift when not stalled, flush kills everything but the tail
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            line[i]     <= '0;
            exp_line[i] <= '0;
         end
      end else if (start_i || !run) begin
         for (int i = 0; i < DEPTH; i++) line[i].valid <= 1'b0;
      end else if (!stall_i) begin
         line[0]     <= '{valid: id_valid_i && !flush_i, chk: m_chk, instr: id_instr_i};
         exp_line[0] <= m_exp;
         for (int i = 1; i < DEPTH; i++) begin
            line[i]     <= '{valid: line[i-1].valid && !flush_i, chk: line[i-1].chk, instr: line[i-1].instr};
            exp_line[i] <= exp_line[i-1];
         end
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH - 1; i++) line[i].valid <= 1'b0;
      end
   end
   // Run control, watchdog and registered check results; start overrides any check in flight
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state              <= IDLE;
         wd                 <= '0;
         done_o             <= 1'b0;
         chk_valid_o        <= 1'b0;
         chk_pass_o         <= 1'b0;
         pass_cnt_o         <= '0;
         fail_cnt_o         <= '0;
         first_fail_instr_o <= '0;
         first_fail_valid_o <= 1'b0;
      end else begin
         chk_valid_o <= 1'b0;
         chk_pass_o  <= 1'b0;
         if (start_i) begin
            state              <= RUN;
            wd                 <= '0;
            done_o             <= 1'b0;
            pass_cnt_o         <= '0;
            fail_cnt_o         <= '0;
            first_fail_instr_o <= '0;
            first_fail_valid_o <= 1'b0;
         end else if (run) begin
            if (wd == WD_W'(TIMEOUT - 1)) begin
               state  <= DONE;
               done_o <= 1'b1;
            end else begin
               wd <= wd + 1'b1;
            end
            if (check) begin
               chk_valid_o <= 1'b1;
               chk_pass_o  <= pass;
               if (pass) begin
                  if (pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + 1'b1;
               end else begin
                  if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + 1'b1;
                  if (!first_fail_valid_o) begin
                     first_fail_valid_o <= 1'b1;
                     first_fail_instr_o <= line[DEPTH-1].instr;
                  end
               end
            end
         end
      end
   end
`ifdef PIPE_CHECK_TRACE_EN
   logic done_q;
   // Trace each check and the tallies on entry into DONE
   always_ff @(posedge clk_i) begin
      done_q <= done_o;
      if (rst_i && check && !start_i)
         $display("pipe_check: instr=%0d expected=%0d actual=%0d", line[DEPTH-1].instr, exp_line[DEPTH-1], alu_result_i);
      if (done_o && !done_q)
         $display("pipe_check: done pass_cnt=%0d fail_cnt=%0d", pass_cnt_o, fail_cnt_o);
   end
`endif
endmodule

// File: doc/pipe_check_monitor.md
# pipe_check_monitor

Synthesizable pipeline result checker for the RISC-V-CPU 5-stage core; parametrised successor to the bench-only EX-result check. Captures each instruction leaving ID with its operand values, carries it down a stall/flush-aware delay line of configurable depth, and compares a reference-model result against the core's ALU result at the check stage. It maintains pass/fail counters, latches the first failing instruction, and ends the run through a cycle-budget watchdog. It sits beside `CPU` in the bench or FPGA debug wrapper and taps ID/EX signals only.

## Interface
- `XLEN`, 32: datapath width.
- `DEPTH`, 2: delay-line entries from ID capture to check point, ≥1.
- `CNT_W`, 16: width of the pass/fail counters.
- `TIMEOUT`, 20: cycles in RUN before forced DONE, ≥1.
- `clk_i`, in, 1: clock; all state on rising edge.
- `rst_i`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: begin a run; clears counters.
- `id_valid_i`, in, 1: ID holds a valid instruction.
- `id_instr_i`, in, 32: ID-stage instruction word.
- `id_rs1_val_i` / `id_rs2_val_i`, in, XLEN: operand values read in ID.
- `stall_i`, in, 1: pipeline stall; delay line holds.
- `flush_i`, in, 1: squash all entries younger than the check point.
- `alu_result_i`, in, XLEN: core ALU result at the check stage.
- `chk_valid_o`, out, 1: a check completed last cycle.
- `chk_pass_o`, out, 1: that check matched.
- `pass_cnt_o` / `fail_cnt_o`, out, CNT_W: saturating counters.
- `first_fail_instr_o`, out, 32: instruction of the first mismatch.
- `first_fail_valid_o`, out, 1: `first_fail_instr_o` is meaningful.
- `done_o`, out, 1: FSM in DONE.

## Operation
- FSM states: IDLE → RUN on `start_i`; RUN → DONE when the cycle counter reaches `TIMEOUT-1`; DONE → RUN on `start_i`. `start_i` in RUN restarts the run: counters, first-fail, watchdog and delay line are cleared.
- Supported ops: opcode 0110011 with funct3=000 (ADD, or SUB when instr[30]=1), 100 XOR, 110 OR, 111 AND. Opcode 0010011 with funct3 000 ADDI, 100 XORI, 110 ORI, 111 ANDI; the immediate is instr[31:20], sign-extended to XLEN. Arithmetic wraps modulo 2^XLEN.
- Any other instruction enters the delay line marked `chk=0` and passes through without a check.
- Capture: in RUN with `id_valid_i && !stall_i`, entry 0 stores {instr, expected, chk}; the expected value is computed at capture.
- Capture rules outside that case:
  - Shift with no valid instruction: inserts a bubble.
  - `stall_i`: holds the whole line.
  - `flush_i`: clears the valid bit of entries 0..DEPTH-2 and blocks capture that cycle. Flush wins over capture and over stall. The tail entry is still checked.
- Check: tail entry valid, `chk=1`, `!stall_i` and RUN → compare `expected == alu_result_i`. The result increments pass or fail, each saturating at 2^CNT_W−1. A fail with `first_fail_valid_o=0` latches the instr.
- In IDLE and DONE, no capture and no checks. Counters and first-fail stay frozen and readable.

## Timing
- Capture → check: DEPTH non-stalled cycles. Check → `chk_valid_o`/`chk_pass_o`/counter update: 1 cycle, registered.
- `chk_valid_o` is a single-cycle pulse per check.
- `done_o` asserts the cycle after the watchdog reaches `TIMEOUT-1`. The watchdog counts every RUN cycle, including stall cycles.
- Reset values: all outputs 0, FSM IDLE, delay line invalid. Reset asserted mid-run discards in-flight entries immediately.
- A check and `start_i` in the same cycle: start wins and the check is dropped.

## Configuration
- `PIPE_CHECK_TRACE_EN` defined: each check prints instruction, expected and actual in decimal via `$display`, and entry into DONE prints both counters. Simulation only; no synthesizable-logic change.
- Undefined: silent; the checker logic is identical.

## Structure
- `pipe_check_pkg` holds:
  - opcode enum (ALU_OP, ALU_OP_I, LOAD, STORE, BRANCH);
  - funct3 constants;
  - the delay-line entry struct;
  - the FSM state enum.
- Sub-module `pipe_check_model`: combinational reference model mapping {instr, rs1, rs2} → {expected, chk}.

## Test plan
- ADDI x1, x0, 5 with rs1=0, DEPTH=2, alu_result=5 two cycles later → `chk_valid_o` pulse with pass, `pass_cnt_o`=1.
- SUB with rs1=3, rs2=5, alu_result=0xFFFFFFFE → pass (wrap). The same instruction with alu_result=2 → fail, `first_fail_instr_o` equals that word, and a second fail leaves it unchanged.
- ADD issued then `stall_i` held 3 cycles → check occurs exactly DEPTH non-stalled cycles after capture, and only once.
- ADD in entry 0 and XORI in the tail, `flush_i` asserted → XORI is checked; the ADD never produces `chk_valid_o`.
- TIMEOUT=20, start then run idle → `done_o`=1 on cycle 21 after start. A later `start_i` → counters 0 and `done_o`=0.
- LOAD/BRANCH words and `rst_i` pulled low mid-run → no checks for non-ALU ops; after reset all outputs are 0 and the FSM is IDLE.
